// File: rtl/ball_motion_ctrl_if.sv
// Handshake/bus bundle between the keyboard decoder, the ball and the motion sequencer.
// The master side drives requests and velocity feedback; the slave side is the sequencer.
interface ball_motion_ctrl_if;
    logic       key_valid;
    logic [3:0] key_dir;
    logic       auto_en;
    logic       pause_tgl;
    logic [1:0] vel_x_fb;
    logic [1:0] vel_y_fb;
    logic [1:0] vel_x_cmd;
    logic [1:0] vel_y_cmd;
    logic [1:0] mode;
    logic       frame_tick;

    modport master (
        output key_valid, key_dir, auto_en, pause_tgl, vel_x_fb, vel_y_fb,
        input  vel_x_cmd, vel_y_cmd, mode, frame_tick
    );

    modport slave (
        input  key_valid, key_dir, auto_en, pause_tgl, vel_x_fb, vel_y_fb,
        output vel_x_cmd, vel_y_cmd, mode, frame_tick
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Per-frame sequencer for the ball velocity commands: arbitrates keyboard vs autopilot,
// supports pause/resume and falls back out of MANUAL after a keyboard inactivity timeout.
module ball_motion_ctrl #(
    parameter int IDLE_FRAMES = 60,
    parameter int CNT_W       = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    ball_motion_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_MANUAL = 2'b01,
        S_AUTO   = 2'b10,
        S_PAUSE  = 2'b11
    } mode_t;

    localparam logic [1:0]       CMD_POS   = 2'b01;
    localparam logic [1:0]       CMD_NEG   = 2'b10;
    localparam logic [1:0]       CMD_STOP  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(IDLE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // key_dir bit order is {up, down, left, right}
    function automatic logic [1:0] key_map_x(input logic [3:0] dir);
        logic [1:0] cmd;
        case ({dir[1], dir[0]})
            2'b01:   cmd = CMD_POS;
            2'b10:   cmd = CMD_NEG;
            default: cmd = CMD_STOP;
        endcase
        return cmd;
    endfunction

    function automatic logic [1:0] key_map_y(input logic [3:0] dir);
        logic [1:0] cmd;
        case ({dir[3], dir[2]})
            2'b01:   cmd = CMD_POS;
            2'b10:   cmd = CMD_NEG;
            default: cmd = CMD_STOP;
        endcase
        return cmd;
    endfunction

    function automatic logic [1:0] auto_map(input logic [1:0] fb);
        return (fb == CMD_NEG) ? CMD_NEG : CMD_POS;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic             r_fclk_s1;
    logic             r_fclk_s2;
    logic             r_fclk_d;
    logic             r_tick;
    logic             r_key_pend;
    logic [3:0]       r_key_dir;
    logic             r_pause_pend;

    mode_t            r_mode;
    logic [1:0]       r_vx;
    logic [1:0]       r_vy;
    logic [CNT_W-1:0] r_cnt;
    mode_t            r_sav_mode;
    logic [1:0]       r_sav_vx;
    logic [1:0]       r_sav_vy;

    mode_t            w_mode_nxt;
    logic [1:0]       w_vx_nxt;
    logic [1:0]       w_vy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    mode_t            w_sav_mode_nxt;
    logic [1:0]       w_sav_vx_nxt;
    logic [1:0]       w_sav_vy_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    // Frame tick: falling edge of the synchronised frame_clk, registered once more
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fclk_s1 <= 1'b0;
            r_fclk_s2 <= 1'b0;
            r_fclk_d  <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_fclk_s1 <= frame_clk;
            r_fclk_s2 <= r_fclk_s1;
            r_fclk_d  <= r_fclk_s2;
            r_tick    <= r_fclk_d & ~r_fclk_s2;
        end
    end

    // Sticky requests; a new event in the tick cycle survives the clear
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_key_pend   <= 1'b0;
            r_key_dir    <= 4'b0000;
            r_pause_pend <= 1'b0;
        end else begin
            if (bus.key_valid) begin
                r_key_pend <= 1'b1;
                r_key_dir  <= bus.key_dir;
            end else if (r_tick) begin
                r_key_pend <= 1'b0;
            end
            if (bus.pause_tgl) begin
                r_pause_pend <= 1'b1;
            end else if (r_tick) begin
                r_pause_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_mode     <= S_IDLE;
            r_vx       <= CMD_STOP;
            r_vy       <= CMD_STOP;
            r_cnt      <= '0;
            r_sav_mode <= S_IDLE;
            r_sav_vx   <= CMD_STOP;
            r_sav_vy   <= CMD_STOP;
        end else begin
            r_mode     <= w_mode_nxt;
            r_vx       <= w_vx_nxt;
            r_vy       <= w_vy_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sav_mode <= w_sav_mode_nxt;
            r_sav_vx   <= w_sav_vx_nxt;
            r_sav_vy   <= w_sav_vy_nxt;
        end
    end

    always_comb begin
        w_mode_nxt     = r_mode;
        w_vx_nxt       = r_vx;
        w_vy_nxt       = r_vy;
        w_cnt_nxt      = r_cnt;
        w_sav_mode_nxt = r_sav_mode;
        w_sav_vx_nxt   = r_sav_vx;
        w_sav_vy_nxt   = r_sav_vy;
        w_cnt_inc      = sat_inc(r_cnt);

        if (r_tick) begin
            if (r_pause_pend && (r_mode != S_PAUSE)) begin
                w_sav_mode_nxt = r_mode;
                w_sav_vx_nxt   = r_vx;
                w_sav_vy_nxt   = r_vy;
                w_mode_nxt     = S_PAUSE;
                w_vx_nxt       = CMD_STOP;
                w_vy_nxt       = CMD_STOP;
            end else if (r_pause_pend) begin
                w_mode_nxt = r_sav_mode;
                w_vx_nxt   = r_sav_vx;
                w_vy_nxt   = r_sav_vy;
                w_cnt_nxt  = '0;
            end else begin
                case (r_mode)
                    S_IDLE: begin
                        if (r_key_pend) begin
                            w_mode_nxt = S_MANUAL;
                            w_vx_nxt   = key_map_x(r_key_dir);
                            w_vy_nxt   = key_map_y(r_key_dir);
                            w_cnt_nxt  = '0;
                        end else if (bus.auto_en) begin
                            w_mode_nxt = S_AUTO;
                            w_vx_nxt   = auto_map(bus.vel_x_fb);
                            w_vy_nxt   = auto_map(bus.vel_y_fb);
                        end
                    end
                    S_MANUAL: begin
                        if (r_key_pend) begin
                            w_vx_nxt  = key_map_x(r_key_dir);
                            w_vy_nxt  = key_map_y(r_key_dir);
                            w_cnt_nxt = '0;
                        end else if (w_cnt_inc >= CNT_LIMIT) begin
                            w_cnt_nxt = '0;
                            if (bus.auto_en) begin
                                w_mode_nxt = S_AUTO;
                                w_vx_nxt   = auto_map(bus.vel_x_fb);
                                w_vy_nxt   = auto_map(bus.vel_y_fb);
                            end else begin
                                w_mode_nxt = S_IDLE;
                                w_vx_nxt   = CMD_STOP;
                                w_vy_nxt   = CMD_STOP;
                            end
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                    S_AUTO: begin
                        if (r_key_pend) begin
                            w_mode_nxt = S_MANUAL;
                            w_vx_nxt   = key_map_x(r_key_dir);
                            w_vy_nxt   = key_map_y(r_key_dir);
                            w_cnt_nxt  = '0;
                        end else if (!bus.auto_en) begin
                            w_mode_nxt = S_IDLE;
                            w_vx_nxt   = CMD_STOP;
                            w_vy_nxt   = CMD_STOP;
                        end else begin
                            w_vx_nxt = auto_map(bus.vel_x_fb);
                            w_vy_nxt = auto_map(bus.vel_y_fb);
                        end
                    end
                    default: begin
                        // Paused with no toggle: hold, pending key is simply consumed
                    end
                endcase
            end
        end
    end

    assign bus.vel_x_cmd  = r_vx;
    assign bus.vel_y_cmd  = r_vy;
    assign bus.mode       = r_mode;
    assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Randomised bench for ball_motion_ctrl against a frame-level behavioural model.
module tb_ball_motion_ctrl;
    localparam int IDLE_FRAMES = 60;
    localparam int M_IDLE = 0, M_MAN = 1, M_AUTO = 2, M_PAUSE = 3;

    logic clk       = 1'b0;
    logic rst_n     = 1'b1;
    logic frame_clk = 1'b1;

    always #5 clk = ~clk;

    ball_motion_ctrl_if bus();

    ball_motion_ctrl #(
        .IDLE_FRAMES(IDLE_FRAMES),
        .CNT_W      (8)
    ) dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .frame_clk(frame_clk),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: what the ball should be commanded after each frame
    int         m_mode, m_x, m_y, m_cnt;
    int         s_mode, s_x, s_y;
    bit         p_key, p_pause;
    logic [3:0] p_dir;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int key_x(input logic [3:0] d);
        if (d[0] && !d[1]) return 1;
        if (d[1] && !d[0]) return 2;
        return 3;
    endfunction

    function automatic int key_y(input logic [3:0] d);
        if (d[2] && !d[3]) return 1;
        if (d[3] && !d[2]) return 2;
        return 3;
    endfunction

    function automatic int follow(input logic [1:0] fb);
        return (fb == 2'b10) ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_x = 3; m_y = 3; m_cnt = 0;
        s_mode = M_IDLE; s_x = 3; s_y = 3;
        p_key = 0; p_pause = 0; p_dir = 4'b0000;
    endtask

    task automatic go_auto_or_idle();
        if (bus.auto_en) begin
            m_mode = M_AUTO; m_x = follow(bus.vel_x_fb); m_y = follow(bus.vel_y_fb);
        end else begin
            m_mode = M_IDLE; m_x = 3; m_y = 3;
        end
    endtask

    // One frame decision, from the pending requests gathered since the previous tick
    task automatic model_tick();
        if (p_pause) begin
            if (m_mode != M_PAUSE) begin
                s_mode = m_mode; s_x = m_x; s_y = m_y;
                m_mode = M_PAUSE; m_x = 3; m_y = 3;
            end else begin
                m_mode = s_mode; m_x = s_x; m_y = s_y; m_cnt = 0;
            end
        end else if (m_mode == M_PAUSE) begin
            m_mode = M_PAUSE;
        end else if (p_key) begin
            m_mode = M_MAN; m_x = key_x(p_dir); m_y = key_y(p_dir); m_cnt = 0;
        end else if (m_mode == M_MAN) begin
            m_cnt++;
            if (m_cnt == IDLE_FRAMES) begin
                m_cnt = 0;
                go_auto_or_idle();
            end
        end else if (m_mode == M_AUTO || bus.auto_en) begin
            go_auto_or_idle();
        end
        p_key = 0;
        p_pause = 0;
    endtask

    task automatic key_pulse(input logic [3:0] d);
        bus.key_valid = 1'b1; bus.key_dir = d;
        @(negedge clk);
        bus.key_valid = 1'b0;
        p_key = 1; p_dir = d;
    endtask

    task automatic pause_pulse();
        bus.pause_tgl = 1'b1;
        @(negedge clk);
        bus.pause_tgl = 1'b0;
        p_pause = 1;
    endtask

    task automatic both_pulse(input logic [3:0] d);
        bus.key_valid = 1'b1; bus.key_dir = d; bus.pause_tgl = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0; bus.pause_tgl = 1'b0;
        p_key = 1; p_dir = d; p_pause = 1;
    endtask

    // Rising frame_clk: commands must hold still around the ball's sampling edge
    task automatic start_frame();
        frame_clk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("stable_x", bus.vel_x_cmd, m_x);
            check_val("stable_y", bus.vel_y_cmd, m_y);
        end
    endtask

    task automatic end_frame(input bit inj, input logic [3:0] d);
        int n;
        bit got;
        n = 0;
        got = 0;
        frame_clk = 1'b0;
        while (n < 8 && !got) begin
            @(negedge clk);
            n++;
            if (bus.frame_tick === 1'b1) got = 1;
        end
        if (!got) begin
            check_val("tick_seen", 0, 1);
            return;
        end
        check_val("tick_lat", n, 3);
        check_val("pre_tick_mode", bus.mode, m_mode);
        check_val("pre_tick_x", bus.vel_x_cmd, m_x);
        if (inj) begin
            bus.key_valid = 1'b1; bus.key_dir = d;
        end
        @(negedge clk);
        bus.key_valid = 1'b0;
        model_tick();
        if (inj) begin
            p_key = 1; p_dir = d;
        end
        check_val("tick_width", bus.frame_tick, 0);
        check_val("mode", bus.mode, m_mode);
        check_val("vel_x", bus.vel_x_cmd, m_x);
        check_val("vel_y", bus.vel_y_cmd, m_y);
    endtask

    task automatic frame();
        start_frame();
        end_frame(1'b0, 4'b0000);
    endtask

    initial begin
        int quiet;
        int r;
        bus.key_valid = 1'b0; bus.key_dir = 4'b0000; bus.auto_en = 1'b0;
        bus.pause_tgl = 1'b0; bus.vel_x_fb = 2'b00; bus.vel_y_fb = 2'b00;
        model_reset();

        #2 rst_n = 1'b0;
        #1;
        check_val("rst_mode", bus.mode, 0);
        check_val("rst_x", bus.vel_x_cmd, 3);
        check_val("rst_y", bus.vel_y_cmd, 3);
        check_val("rst_tick", bus.frame_tick, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Keyboard right in IDLE, then inactivity timeout back to IDLE
        start_frame(); key_pulse(4'b0001); end_frame(1'b0, 4'b0000);
        check_val("t2_mode", bus.mode, 1);
        check_val("t2_x", bus.vel_x_cmd, 1);
        check_val("t2_y", bus.vel_y_cmd, 3);
        for (int i = 0; i < IDLE_FRAMES - 1; i++) frame();
        check_val("t2_still_manual", bus.mode, 1);
        frame();
        check_val("t2_timeout_mode", bus.mode, 0);
        check_val("t2_timeout_x", bus.vel_x_cmd, 3);

        // Autopilot follows feedback, then a key takes over
        bus.auto_en = 1'b1; bus.vel_x_fb = 2'b10; bus.vel_y_fb = 2'b01;
        frame();
        check_val("t3_mode", bus.mode, 2);
        check_val("t3_x", bus.vel_x_cmd, 2);
        check_val("t3_y", bus.vel_y_cmd, 1);
        start_frame(); key_pulse(4'b1010); end_frame(1'b0, 4'b0000);
        check_val("t3_key_mode", bus.mode, 1);
        check_val("t3_key_y", bus.vel_y_cmd, 2);

        // Pause / ignored key / resume
        start_frame(); key_pulse(4'b0001); end_frame(1'b0, 4'b0000);
        start_frame(); pause_pulse(); end_frame(1'b0, 4'b0000);
        check_val("t4_pause_mode", bus.mode, 3);
        check_val("t4_pause_x", bus.vel_x_cmd, 3);
        start_frame(); key_pulse(4'b0100); end_frame(1'b0, 4'b0000);
        check_val("t4_key_ignored", bus.mode, 3);
        start_frame(); pause_pulse(); end_frame(1'b0, 4'b0000);
        check_val("t4_resume_mode", bus.mode, 1);
        check_val("t4_resume_x", bus.vel_x_cmd, 1);

        // Pause beats key in the same cycle; key in the tick cycle waits a frame
        start_frame(); both_pulse(4'b0010); end_frame(1'b0, 4'b0000);
        check_val("t5_pause_wins", bus.mode, 3);
        start_frame(); pause_pulse(); end_frame(1'b0, 4'b0000);
        check_val("t5_restore_x", bus.vel_x_cmd, 1);
        start_frame(); end_frame(1'b1, 4'b1000);
        check_val("t5_tick_key_late", bus.vel_y_cmd, 3);
        frame();
        check_val("t5_tick_key_y", bus.vel_y_cmd, 2);
        check_val("t5_tick_key_x", bus.vel_x_cmd, 3);

        // Conflicting directions stop that axis
        start_frame(); key_pulse(4'b0011); end_frame(1'b0, 4'b0000);
        check_val("t6_lr_x", bus.vel_x_cmd, 3);
        start_frame(); key_pulse(4'b1100); end_frame(1'b0, 4'b0000);
        check_val("t6_ud_y", bus.vel_y_cmd, 3);
        start_frame(); key_pulse(4'b0110); end_frame(1'b0, 4'b0000);
        check_val("t6_dl_x", bus.vel_x_cmd, 2);
        check_val("t6_dl_y", bus.vel_y_cmd, 1);

        // Asynchronous reset between the frame_clk fall and its tick
        start_frame();
        frame_clk = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("t1_rst_mode", bus.mode, 0);
        check_val("t1_rst_x", bus.vel_x_cmd, 3);
        check_val("t1_rst_y", bus.vel_y_cmd, 3);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("t1_no_tick", bus.frame_tick, 0);
        end
        frame();

        // Randomised frames, with occasional long quiet stretches for the timeout
        quiet = 0;
        for (int f = 0; f < 240; f++) begin
            if ($urandom_range(0, 7) == 0) bus.auto_en = ~bus.auto_en;
            bus.vel_x_fb = 2'($urandom_range(0, 3));
            bus.vel_y_fb = 2'($urandom_range(0, 3));
            start_frame();
            r = $urandom_range(0, 9);
            if (quiet > 0) begin
                quiet--;
                r = 0;
            end
            case (r)
                5, 6: key_pulse(4'($urandom_range(0, 15)));
                7:    pause_pulse();
                8: begin
                    key_pulse(4'($urandom_range(0, 15)));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    key_pulse(4'($urandom_range(0, 15)));
                end
                9:    both_pulse(4'($urandom_range(0, 15)));
                default: ;
            endcase
            end_frame((quiet == 0) && ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
            if (f % 80 == 10) quiet = IDLE_FRAMES + 5;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
